// File: rtl/bit_serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial adder controller.
package bit_serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int SETTLE_W = 4;

  function automatic int idx_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/mux4to1_slice.sv
// Gate-level one-bit full adder: sum and carry are 4:1 muxes selected by {a,b}.
module mux4to1_slice (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic [3:0] sel;

  assign sel[0] = ~a & ~b;
  assign sel[1] = ~a &  b;
  assign sel[2] =  a & ~b;
  assign sel[3] =  a &  b;

  // Data inputs of the sum mux are {cin, ~cin, ~cin, cin}; carry mux is {0, cin, cin, 1}.
  assign sum  = (sel[0] & cin) | (sel[1] & ~cin) | (sel[2] & ~cin) | (sel[3] & cin);
  assign cout = (sel[1] & cin) | (sel[2] & cin) | sel[3];

endmodule

// File: rtl/bit_serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder sequencing one full-adder slice LSB-first.
// Optional subtract support is enabled with the SERIAL_ADD_SUB_EN macro.
module bit_serial_add_ctrl
  import bit_serial_add_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout_out
);

  localparam int IDX_W = idx_width(WIDTH);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC);
  localparam logic [IDX_W-1:0]    IDX_LAST    = IDX_W'(WIDTH - 1);

  state_t state, state_nxt;

  logic [WIDTH-1:0]    a_sh, b_sh;
  logic                carry;
  logic [IDX_W-1:0]    idx;
  logic [SETTLE_W-1:0] cnt;

  logic slice_a, slice_b, slice_cin, slice_sum, slice_cout;
  logic step, last_step;

  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  // Subtraction is A + ~B + 1, so only the loaded operand and carry change.
  always_comb begin
    b_load     = b_in;
    carry_load = cin_in;
`ifdef SERIAL_ADD_SUB_EN
    if (sub) begin
      b_load     = ~b_in;
      carry_load = 1'b1;
    end
`endif
  end

  assign step      = (state == RUN) && (cnt == SETTLE_LAST);
  assign last_step = step && (idx == IDX_LAST);

  assign slice_a   = (state == RUN) & a_sh[0];
  assign slice_b   = (state == RUN) & b_sh[0];
  assign slice_cin = (state == RUN) & carry;

  mux4to1_slice u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (slice_cin),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy/done are registered from the state, which places them one cycle after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      cnt      <= '0;
      result   <= '0;
      cout_out <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      busy <= (state == RUN);
      done <= (state == DONE);
      if (state == IDLE && start) begin
        a_sh     <= a_in;
        b_sh     <= b_load;
        carry    <= carry_load;
        idx      <= '0;
        cnt      <= '0;
        result   <= '0;
        cout_out <= 1'b0;
      end else if (state == RUN) begin
        if (step) begin
          result <= {slice_sum, result[WIDTH-1:1]};
          carry  <= slice_cout;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= '0;
          idx    <= idx + IDX_W'(1);
          if (last_step) cout_out <= slice_cout;
        end else begin
          cnt <= cnt + SETTLE_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
// Directed scoreboard bench for bit_serial_add_ctrl (SETTLE_CYC=1 and 3 instances).
module tb_bit_serial_add_ctrl;

  typedef struct packed {
    logic [7:0] r;
    logic       c;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       start3 = 1'b0;
  logic [7:0] a_in = 8'h00;
  logic [7:0] b_in = 8'h00;
  logic       cin_in = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
  logic       sub = 1'b0;
`endif

  logic       busy, done, cout_out;
  logic [7:0] result;
  logic       busy3, done3, cout3;
  logic [7:0] result3;

  exp_t exp_q[$];
  exp_t last_e;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  bit_serial_add_ctrl #(.WIDTH(8), .SETTLE_CYC(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .cin_in   (cin_in),
`ifdef SERIAL_ADD_SUB_EN
    .sub      (sub),
`endif
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout_out (cout_out)
  );

  bit_serial_add_ctrl #(.WIDTH(8), .SETTLE_CYC(3)) dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start3),
    .a_in     (a_in),
    .b_in     (b_in),
    .cin_in   (cin_in),
`ifdef SERIAL_ADD_SUB_EN
    .sub      (sub),
`endif
    .busy     (busy3),
    .done     (done3),
    .result   (result3),
    .cout_out (cout3)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one start request and pushes the model's answer when a result is expected.
  task automatic applyStimulus(input bit which, input logic [7:0] a, input logic [7:0] b,
                               input logic c, input logic sb, input bit expect_done);
    logic [8:0] full;
    logic [7:0] bb;
    logic       cc;
    @(negedge clk);
    a_in   = a;
    b_in   = b;
    cin_in = c;
`ifdef SERIAL_ADD_SUB_EN
    sub = sb;
`endif
    bb   = sb ? ~b : b;
    cc   = sb ? 1'b1 : c;
    full = {1'b0, a} + {1'b0, bb} + {8'd0, cc};
    if (expect_done) exp_q.push_back('{r: full[7:0], c: full[8]});
    if (which) start3 = 1'b1;
    else       start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic runOp(input bit which, input int settle, input int inject_at, input int extra);
    int         total;
    int         last;
    logic       b_o, d_o, c_o;
    logic [7:0] r_o;
    exp_t       e;
    total = 8 * (settle + 1);
    last  = total + 1 + extra;
    for (int cyc = 1; cyc <= last; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == inject_at - 1) begin
        a_in  = 8'hFF;
        b_in  = 8'hFF;
        start = 1'b1;
      end
      if (cyc == inject_at) start = 1'b0;
      b_o = which ? busy3   : busy;
      d_o = which ? done3   : done;
      r_o = which ? result3 : result;
      c_o = which ? cout3   : cout_out;
      checkOutput($sformatf("busy_c%0d", cyc), 32'(b_o), 32'(cyc <= total));
      checkOutput($sformatf("done_c%0d", cyc), 32'(d_o), 32'(cyc == total + 1));
      if (d_o) begin
        checkOutput("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          last_e = e;
          checkOutput("result", 32'(r_o), 32'(e.r));
          checkOutput("cout_out", 32'(c_o), 32'(e.c));
        end
      end else if (cyc > total + 1) begin
        checkOutput($sformatf("result_hold_c%0d", cyc), 32'(r_o), 32'(last_e.r));
        checkOutput($sformatf("cout_hold_c%0d", cyc), 32'(c_o), 32'(last_e.c));
      end
    end
  endtask

  initial begin
    last_e = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_result", 32'(result), 32'd0);
    checkOutput("rst_cout", 32'(cout_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1'b0, 8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1);
    runOp(1'b0, 1, 0, 3);

    // Second operation is issued in the done cycle so it lands right after done.
    applyStimulus(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
    runOp(1'b0, 1, 0, 0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    runOp(1'b0, 1, 0, 2);

    applyStimulus(1'b0, 8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
    runOp(1'b0, 1, 5, 5);

    applyStimulus(1'b0, 8'hAA, 8'h55, 1'b0, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("pre_abort_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_result", 32'(result), 32'd0);
    checkOutput("abort_cout", 32'(cout_out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("abort_nodone_%0d", i), 32'(done), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'hAA, 8'h55, 1'b0, 1'b0, 1'b1);
    runOp(1'b0, 1, 0, 1);

    applyStimulus(1'b1, 8'h80, 8'h80, 1'b0, 1'b0, 1'b1);
    runOp(1'b1, 3, 0, 2);

`ifdef SERIAL_ADD_SUB_EN
    applyStimulus(1'b0, 8'h10, 8'h01, 1'b0, 1'b1, 1'b1);
    runOp(1'b0, 1, 0, 1);
    applyStimulus(1'b0, 8'h01, 8'h02, 1'b0, 1'b1, 1'b1);
    runOp(1'b0, 1, 0, 1);
`endif

    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
